// File: rtl/module_rx_arbiter.sv
// Four-lane receive arbiter: 1-deep buffer per lane, round-robin grant into a registered output.
// Define RX_ARBITER_PRIO_EN to give lane 0 absolute priority over lanes 1-3.
module module_rx_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic                  clk_rx_arbiter,
  input  logic                  reset_L,
  input  logic [3:0]            lane_en,
  input  logic [3:0]            valid_in,
  input  logic [4*DATA_W-1:0]   data_in,
  output logic [3:0]            ready_out,
  input  logic                  ready_in,
  output logic                  valid_out,
  output logic [DATA_W-1:0]     data_out,
  output logic [1:0]            lane_id_out
);

  localparam int LANES = 4;

  logic [3:0]        full_q, full_d;
  logic [DATA_W-1:0] buf_q [LANES];
  logic [DATA_W-1:0] buf_d [LANES];
  logic [1:0]        ptr_q, ptr_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        id_q, id_d;

  logic [3:0] elig, cand, capture, clr, rot;
  logic [7:0] dbl, shifted;
  logic [2:0] sh;
  logic [1:0] off, gnt;
  logic       adv, rr_vld, gnt_vld, upd_ptr;

  // Reset gating keeps every lane closed while reset_L is held low.
  assign ready_out   = ~full_q & lane_en & {4{reset_L}};
  assign capture     = valid_in & ready_out;
  assign elig        = full_q & lane_en;
  assign adv         = ~valid_q | ready_in;
  assign valid_out   = valid_q;
  assign data_out    = data_q;
  assign lane_id_out = id_q;

`ifdef RX_ARBITER_PRIO_EN
  assign cand = elig & 4'b1110;
`else
  assign cand = elig;
`endif

  // Rotate so bit 0 is the lane after ptr; lowest set bit wins.
  always_comb begin
    dbl     = {cand, cand};
    sh      = {1'b0, ptr_q} + 3'd1;
    shifted = dbl >> sh;
    rot     = shifted[3:0];
    rr_vld  = 1'b0;
    off     = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (rot[i]) begin
        rr_vld = 1'b1;
        off    = 2'(i);
      end
    end
  end

  always_comb begin
    gnt     = ptr_q + 2'd1 + off;
    gnt_vld = rr_vld;
    upd_ptr = rr_vld;
`ifdef RX_ARBITER_PRIO_EN
    if (elig[0]) begin
      gnt     = 2'd0;
      gnt_vld = 1'b1;
      upd_ptr = 1'b0;
    end
`endif
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    clr     = 4'd0;
    for (int i = 0; i < LANES; i++) begin
      buf_d[i] = buf_q[i];
      if (capture[i]) buf_d[i] = data_in[DATA_W*i +: DATA_W];
    end
    if (adv) begin
      if (gnt_vld) begin
        valid_d  = 1'b1;
        data_d   = buf_q[gnt];
        id_d     = gnt;
        clr[gnt] = 1'b1;
        if (upd_ptr) ptr_d = gnt;
      end else begin
        valid_d = 1'b0;
      end
    end
    // A granted lane is full, a capturing lane is empty: never the same lane.
    full_d = (full_q & ~clr) | capture;
  end

  always_ff @(posedge clk_rx_arbiter or negedge reset_L) begin
    if (!reset_L) begin
      full_q  <= 4'd0;
      ptr_q   <= 2'd3;
      valid_q <= 1'b0;
      data_q  <= '0;
      id_q    <= 2'd0;
      for (int i = 0; i < LANES; i++) buf_q[i] <= '0;
    end else begin
      full_q  <= full_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      id_q    <= id_d;
      for (int i = 0; i < LANES; i++) buf_q[i] <= buf_d[i];
    end
  end

endmodule

// File: tb/tb_module_rx_arbiter.sv
// Bench for module_rx_arbiter: lane-level reference model checked every cycle
// plus directed scenarios with literal expectations.
module tb_module_rx_arbiter;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    lane_en = 4'h0;
  logic [3:0]    valid_in = 4'h0;
  logic [4*DW-1:0] data_in = '0;
  logic [3:0]    ready_out;
  logic          ready_in = 1'b0;
  logic          valid_out;
  logic [DW-1:0] data_out;
  logic [1:0]    lane_id_out;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  module_rx_arbiter #(.DATA_W(DW)) dut (
    .clk_rx_arbiter(clk),
    .reset_L(rst_n),
    .lane_en(lane_en),
    .valid_in(valid_in),
    .data_in(data_in),
    .ready_out(ready_out),
    .ready_in(ready_in),
    .valid_out(valid_out),
    .data_out(data_out),
    .lane_id_out(lane_id_out)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int n, input logic [31:0] v);
    data_in[DW*n +: DW] = v;
  endtask

  // Reference model: each lane is a one-word slot; output is one register.
  bit          m_full [4];
  logic [31:0] m_buf  [4];
  int          m_ptr = 3;
  bit          m_vo  = 0;
  logic [31:0] m_do  = '0;
  int          m_id  = 0;
  bit          m_rdy [4];
  bit          m_elg [4];
  int          m_g;
  int          m_l;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        m_full[i] = 0;
        m_buf[i]  = '0;
      end
      m_ptr = 3;
      m_vo  = 0;
      m_do  = '0;
      m_id  = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        m_rdy[i] = !m_full[i] && lane_en[i];
        m_elg[i] = m_full[i] && lane_en[i];
      end
      m_g = -1;
`ifdef RX_ARBITER_PRIO_EN
      if (m_elg[0]) m_g = 0;
`endif
      for (int k = 1; k <= 4; k++) begin
        m_l = (m_ptr + k) % 4;
`ifdef RX_ARBITER_PRIO_EN
        if (m_l == 0) continue;
`endif
        if (m_g < 0 && m_elg[m_l]) m_g = m_l;
      end
      if (!m_vo || ready_in) begin
        if (m_g >= 0) begin
          m_vo = 1;
          m_do = m_buf[m_g];
          m_id = m_g;
          m_full[m_g] = 0;
`ifdef RX_ARBITER_PRIO_EN
          if (m_g != 0) m_ptr = m_g;
`else
          m_ptr = m_g;
`endif
        end else begin
          m_vo = 0;
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (valid_in[i] && m_rdy[i]) begin
          m_full[i] = 1;
          m_buf[i]  = data_in[DW*i +: DW];
        end
      end
    end
  end

  logic [3:0] m_ready;

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++)
      m_ready[i] = rst_n && !m_full[i] && lane_en[i];
    chk("model_valid", valid_out, m_vo);
    chk("model_data", data_out, m_do);
    chk("model_id", lane_id_out, m_id);
    chk("model_ready", ready_out, m_ready);
  end

  int prev;

  initial begin
    lane_en  = 4'hF;
    ready_in = 1'b1;
    repeat (2) step();
    chk("rst_valid", valid_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_id", lane_id_out, 0);
    chk("rst_ready", ready_out, 0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", ready_out, 4'hF);

    // all four lanes full at once
    for (int i = 0; i < 4; i++) set_lane(i, 32'hC0DE_0000 + i);
    valid_in = 4'hF;
    step();
    valid_in = 4'h0;
    chk("all_full_ready", ready_out, 4'h0);
    chk("all_full_valid", valid_out, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_valid", valid_out, 1);
      chk("rr_id", lane_id_out, i);
      chk("rr_data", data_out, 32'hC0DE_0000 + i);
    end
    step();
    chk("rr_drain", valid_out, 0);

    // single word on lane 2
    set_lane(2, 32'hA5A5_0002);
    valid_in = 4'b0100;
    step();
    valid_in = 4'h0;
    chk("l2_busy_ready", ready_out, 4'b1011);
    chk("l2_not_yet", valid_out, 0);
    step();
    chk("l2_valid", valid_out, 1);
    chk("l2_data", data_out, 32'hA5A5_0002);
    chk("l2_id", lane_id_out, 2);
    chk("l2_free_ready", ready_out, 4'hF);
    step();
    chk("l2_done", valid_out, 0);

    // lanes 1 and 3 streaming
    valid_in = 4'b1010;
    prev = -1;
    for (int i = 0; i < 10; i++) begin
      set_lane(1, 32'h1000_0000 | i);
      set_lane(3, 32'h3000_0000 | i);
      step();
      if (i >= 1) chk("stream_valid", valid_out, 1);
      if (i >= 2) chk("stream_alt", lane_id_out, (prev == 1) ? 3 : 1);
      prev = int'(lane_id_out);
    end
    valid_in = 4'h0;
    repeat (3) step();
    chk("stream_drain", valid_out, 0);

    // back-pressure hold
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    ready_in = 1'b0;
    for (int i = 0; i < 3; i++) set_lane(i, 32'hB000_0000 + i);
    valid_in = 4'b0111;
    step();
    valid_in = 4'h0;
    step();
    chk("hold_first_valid", valid_out, 1);
    chk("hold_first_id", lane_id_out, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_valid", valid_out, 1);
      chk("hold_id", lane_id_out, 0);
      chk("hold_data", data_out, 32'hB000_0000);
      chk("hold_ready", ready_out, 4'b1001);
    end
    ready_in = 1'b1;
    step();
    chk("hold_next_id", lane_id_out, 1);
    chk("hold_next_data", data_out, 32'hB000_0001);

    // asynchronous reset mid-stream discards lane 2
    rst_n = 1'b0;
    #1;
    chk("async_valid", valid_out, 0);
    chk("async_ready", ready_out, 0);
    chk("async_data", data_out, 0);
    step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("discarded", valid_out, 0);

    // lane 1 disabled while full
    set_lane(1, 32'hD1D1_0001);
    valid_in = 4'b0010;
    step();
    valid_in = 4'h0;
    lane_en  = 4'b1101;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("dis_valid", valid_out, 0);
      chk("dis_ready", ready_out, 4'b1101);
    end
    lane_en = 4'hF;
    step();
    chk("reen_valid", valid_out, 1);
    chk("reen_id", lane_id_out, 1);
    chk("reen_data", data_out, 32'hD1D1_0001);
    step();
    chk("reen_once", valid_out, 0);

`ifdef RX_ARBITER_PRIO_EN
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    valid_in = 4'b0101;
    for (int i = 0; i < 8; i++) begin
      set_lane(0, 32'h0000_0A00 | i);
      set_lane(2, 32'h0000_0C00 | i);
      step();
      if (i >= 1) chk("prio_id", lane_id_out, (i % 2 == 1) ? 0 : 2);
    end
    valid_in = 4'h0;
    repeat (3) step();
`endif

    // mixed traffic, model-checked every cycle
    for (int i = 0; i < 400; i++) begin
      lane_en  = ($urandom_range(3) == 0) ? 4'($urandom) : 4'hF;
      valid_in = 4'($urandom);
      ready_in = ($urandom_range(2) != 0);
      data_in  = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    valid_in = 4'h0;
    lane_en  = 4'hF;
    ready_in = 1'b1;
    repeat (8) step();
    chk("final_idle", valid_out, 0);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
